// File: rtl/reset_sequencer_pkg.sv
// Shared types and default configuration for the reset sequencer.
// The software-reset feature is selected by RESET_SEQUENCER_SW_RESET_EN.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ASSERT     = 2'd0,
    WAIT_DELAY = 2'd1,
    RELEASE    = 2'd2,
    DONE       = 2'd3
  } state_e;

  localparam int DEF_NUM_CHANNELS      = 4;
  localparam int DEF_SYNC_STAGES       = 2;
  localparam int DEF_DELAY_CYCLES      = 16;
  localparam int DEF_GAP_CYCLES        = 4;
  localparam int DEF_MIN_ASSERT_CYCLES = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Asynchronous-assert, synchronous-deassert reset synchronizer.
// Output is active-low and only rises after SYNC_STAGES rising clock edges.
module reset_sync
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset_n,
  output logic rst_sync_n
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("reset_sync: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  // NOTE: every stage is cleared asynchronously so assertion never waits for a clock,
  // while deassertion has to ripple through the whole chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: channel 0 after DELAY_CYCLES, then one channel every GAP_CYCLES.
// Define RESET_SEQUENCER_SW_RESET_EN to honour sw_reset_req; otherwise the port is ignored.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_CHANNELS      = DEF_NUM_CHANNELS,
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int DELAY_CYCLES      = DEF_DELAY_CYCLES,
  parameter int GAP_CYCLES        = DEF_GAP_CYCLES,
  parameter int MIN_ASSERT_CYCLES = DEF_MIN_ASSERT_CYCLES
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    sw_reset_req,
  input  logic                    hold,
  output logic [NUM_CHANNELS-1:0] reset_out,
  output logic                    ready
);

  if (NUM_CHANNELS < 1) begin : g_bad_num_channels
    $error("reset_sequencer: NUM_CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (DELAY_CYCLES < 1) begin : g_bad_delay_cycles
    $error("reset_sequencer: DELAY_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap_cycles
    $error("reset_sequencer: GAP_CYCLES must be >= 1");
  end
  if (MIN_ASSERT_CYCLES < 1) begin : g_bad_min_assert_cycles
    $error("reset_sequencer: MIN_ASSERT_CYCLES must be >= 1");
  end

  localparam int CNT_MAX = max3(DELAY_CYCLES, GAP_CYCLES, MIN_ASSERT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Counter compares against the last value so it never reaches CNT_MAX and cannot wrap.
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        cnt_last;
  logic [NUM_CHANNELS-1:0] reset_out_q, reset_out_d;
  logic [NUM_CHANNELS-1:0] rel_next;
  logic                    ready_q, ready_d;
  logic                    rst_sync_n;

  reset_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_reset_sync (
    .clock     (clock),
    .reset_n   (reset_n),
    .rst_sync_n(rst_sync_n)
  );

`ifdef RESET_SEQUENCER_SW_RESET_EN
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_ASSERT_CYCLES - 1);

  // Set by a software request: ASSERT must then last MIN_ASSERT_CYCLES before leaving.
  logic sw_min_q, sw_min_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sw_min_q <= 1'b0;
    end else begin
      sw_min_q <= sw_min_d;
    end
  end
`else
  logic sw_reset_unused;
  assign sw_reset_unused = sw_reset_req;
`endif

  // NOTE: every variable gets its default first so no path through the case leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reset_out_d = reset_out_q;
    ready_d     = ready_q;
    rel_next    = reset_out_q << 1;
    cnt_last    = (state_q == WAIT_DELAY) ? DELAY_LAST : GAP_LAST;
`ifdef RESET_SEQUENCER_SW_RESET_EN
    sw_min_d    = sw_min_q;
`endif

    unique case (state_q)
      ASSERT: begin
        reset_out_d = '1;
        ready_d     = 1'b0;
`ifdef RESET_SEQUENCER_SW_RESET_EN
        if (sw_min_q && (cnt_q != MIN_LAST)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (rst_sync_n && (!sw_min_q || (cnt_q == MIN_LAST))) begin
          state_d  = WAIT_DELAY;
          cnt_d    = '0;
          sw_min_d = 1'b0;
        end
`else
        if (rst_sync_n) begin
          state_d = WAIT_DELAY;
          cnt_d   = '0;
        end
`endif
      end

      // Release shifts a zero in from bit 0; all-zero after the shift means the last channel.
      WAIT_DELAY, RELEASE: begin
        if (!hold) begin
          if (cnt_q == cnt_last) begin
            reset_out_d = rel_next;
            cnt_d       = '0;
            if (rel_next == '0) begin
              state_d = DONE;
              ready_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        ready_d = 1'b1;
      end

      default: begin
        state_d = ASSERT;
      end
    endcase

`ifdef RESET_SEQUENCER_SW_RESET_EN
    // Software request overrides everything, including hold.
    if (sw_reset_req) begin
      state_d     = ASSERT;
      cnt_d       = '0;
      reset_out_d = '1;
      ready_d     = 1'b0;
      sw_min_d    = 1'b1;
    end
`endif
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ASSERT;
      cnt_q       <= '0;
      reset_out_q <= '1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reset_out_q <= reset_out_d;
      ready_q     <= ready_d;
    end
  end

  assign reset_out = reset_out_q;
  assign ready     = ready_q;

endmodule
